// File: rtl/ahb_ram_ctrl_pkg.sv
// Shared AHB-Lite encodings, controller FSM states and byte-lane helpers for ahb_ram_ctrl.
package ahb_ram_ctrl_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_OK,
        ST_STALL,
        ST_ERR1,
        ST_ERR2
    } ahb_state_t;

    // Oversize, or not naturally aligned for its size.
    function automatic logic size_illegal(input logic [2:0] size, input logic [1:0] addr);
        return (size > HSIZE_WORD) ||
               ((size == HSIZE_HALF) && addr[0]) ||
               ((size == HSIZE_WORD) && (addr != 2'b00));
    endfunction

    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] addr);
        case (size)
            HSIZE_BYTE: return 4'b0001 << addr;
            HSIZE_HALF: return addr[1] ? 4'b1100 : 4'b0011;
            default:    return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ram_write_buffer.sv
// One-entry posted write buffer with per-byte read forwarding onto RAM read data.
// Latency: fill/drain take effect at the clock edge; forwarding is combinational.
// Backpressure: none; the owner must drain before refilling a full entry (fill wins over drain).
module ram_write_buffer #(
    parameter int AW = 12
) (
    input  logic          core_clk,
    input  logic          arst_n,
    input  logic          fill,
    input  logic [AW-1:0] fill_addr,
    input  logic [3:0]    fill_mask,
    input  logic [31:0]   fill_dat,
    input  logic          drain,
    output logic          buf_vld,
    output logic [AW-1:0] buf_addr,
    output logic [3:0]    buf_mask,
    output logic [31:0]   buf_dat,
    input  logic [AW-1:0] rd_addr,
    input  logic [31:0]   ram_dat,
    output logic [31:0]   rd_dat
);

    logic hit;

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            buf_vld  <= 1'b0;
            buf_addr <= '0;
            buf_mask <= '0;
            buf_dat  <= '0;
        end else if (fill) begin
            buf_vld  <= 1'b1;
            buf_addr <= fill_addr;
            buf_mask <= fill_mask;
            buf_dat  <= fill_dat;
        end else if (drain) begin
            buf_vld  <= 1'b0;
        end
    end

    assign hit = buf_vld && (buf_addr == rd_addr);

    always_comb begin
        rd_dat = ram_dat;
        for (int i = 0; i < 4; i++) begin
            if (hit && buf_mask[i]) begin
                rd_dat[8*i +: 8] = buf_dat[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/ahb_ram_ctrl.sv
// AHB-Lite slave fronting a single-port synchronous SRAM through a one-entry posted write buffer.
// Latency: zero wait states; read data is returned in the cycle after the address phase.
// Backpressure: one HREADYOUT=0 cycle on write-data/full-buffer/read-address collision; two-cycle ERROR on illegal sizes.
module ahb_ram_ctrl
    import ahb_ram_ctrl_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          HSEL,
    input  logic [31:0]   HADDR,
    input  logic [1:0]    HTRANS,
    input  logic [2:0]    HSIZE,
    input  logic          HWRITE,
    input  logic          HREADY,
    input  logic [31:0]   HWDATA,
    output logic          HREADYOUT,
    output logic          HRESP,
    output logic [31:0]   HRDATA,
    output logic          RAM_EN,
    output logic [3:0]    RAM_WE,
    output logic [AW-1:0] RAM_A,
    output logic [31:0]   RAM_Di,
    input  logic [31:0]   RAM_Do
);

    ahb_state_t    state_q, state_cur, state_d;
    logic          addr_vld, acc, illegal, conflict, stall;
    logic          read_issue, capture, commit;
    logic [AW-1:0] word_addr;
    logic          dp_write, dp_read;
    logic [AW-1:0] dp_addr;
    logic [3:0]    dp_mask;
    logic          buf_vld;
    logic [AW-1:0] buf_addr;
    logic [3:0]    buf_mask;
    logic [31:0]   buf_dat, fwd_dat;
    logic          addr_unused;

    // Upper address bits alias onto the RAM; HTRANS[0] only separates SEQ from NONSEQ.
    assign addr_unused = ^{HADDR[31:AW+2], HTRANS[0]};

    assign addr_vld  = HSEL & HTRANS[1];
    assign acc       = addr_vld & HREADY;
    assign illegal   = size_illegal(HSIZE, HADDR[1:0]);
    assign word_addr = HADDR[AW+1:2];

    // The write data phase must be extended in the very cycle the collision is seen,
    // so STALL is decoded from OK combinationally rather than registered first.
    assign conflict = dp_write & buf_vld & addr_vld & ~HWRITE & ~illegal;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state_q <= ST_OK;
        else          state_q <= state_d;
    end

    always_comb begin
        state_cur = state_q;
        if ((state_q == ST_OK) && conflict) state_cur = ST_STALL;
        state_d   = state_cur;
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        case (state_cur)
            ST_OK: begin
                if (acc && illegal) state_d = ST_ERR1;
            end
            ST_STALL: begin
                HREADYOUT = 1'b0;
                state_d   = ST_OK;
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
                state_d   = ST_ERR2;
            end
            ST_ERR2: begin
                HRESP   = HRESP_ERROR;
                state_d = (acc && illegal) ? ST_ERR1 : ST_OK;
            end
            default: state_d = ST_OK;
        endcase
    end

    assign stall      = (state_cur == ST_STALL);
    assign read_issue = HRESETn & acc & ~illegal & ~HWRITE & ~stall;
    assign capture    = dp_write & HREADYOUT;
    assign commit     = buf_vld & ~read_issue;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_write <= 1'b0;
            dp_read  <= 1'b0;
            dp_addr  <= '0;
            dp_mask  <= '0;
        end else if (HREADY) begin
            dp_write <= acc & ~illegal & HWRITE;
            dp_read  <= acc & ~illegal & ~HWRITE;
            if (acc) begin
                dp_addr <= word_addr;
                dp_mask <= lane_mask(HSIZE, HADDR[1:0]);
            end
        end
    end

    ram_write_buffer #(.AW(AW)) u_wbuf (
        .core_clk  (HCLK),
        .arst_n    (HRESETn),
        .fill      (capture),
        .fill_addr (dp_addr),
        .fill_mask (dp_mask),
        .fill_dat  (HWDATA),
        .drain     (commit),
        .buf_vld   (buf_vld),
        .buf_addr  (buf_addr),
        .buf_mask  (buf_mask),
        .buf_dat   (buf_dat),
        .rd_addr   (dp_addr),
        .ram_dat   (RAM_Do),
        .rd_dat    (fwd_dat)
    );

    assign HRDATA = dp_read ? fwd_dat : 32'h0;

    assign RAM_EN = read_issue | commit;
    assign RAM_WE = commit ? buf_mask : 4'b0000;
    assign RAM_A  = read_issue ? word_addr : buf_addr;
    assign RAM_Di = buf_dat;

endmodule

// File: tb/tb_ahb_ram_ctrl.sv
// Directed bench for ahb_ram_ctrl with a behavioural 4Kx32 SRAM and HREADY looped from HREADYOUT.
module tb_ahb_ram_ctrl;
    import ahb_ram_ctrl_pkg::*;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic        RAM_EN;
    logic [3:0]  RAM_WE;
    logic [11:0] RAM_A;
    logic [31:0] RAM_Di;
    logic [31:0] RAM_Do = 32'h0;

    logic [31:0] mem [0:4095] = '{default: 32'h0};
    bit          preloaded = 1'b0;
    int          ram_wr_cnt = 0;
    int          checks = 0;
    int          errors = 0;
    int          wr_base;

    assign HREADY = HREADYOUT;

    always #5 HCLK = ~HCLK;

    ahb_ram_ctrl #(.AW(12)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HSIZE     (HSIZE),
        .HWRITE    (HWRITE),
        .HREADY    (HREADY),
        .HWDATA    (HWDATA),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA),
        .RAM_EN    (RAM_EN),
        .RAM_WE    (RAM_WE),
        .RAM_A     (RAM_A),
        .RAM_Di    (RAM_Di),
        .RAM_Do    (RAM_Do)
    );

    always @(posedge HCLK) begin
        if (!preloaded) begin
            mem[0]    <= 32'h55667788;
            mem[8]    <= 32'h11223344;
            preloaded <= 1'b1;
        end else if (RAM_EN) begin
            if (RAM_WE == 4'b0000) begin
                RAM_Do <= mem[RAM_A];
            end else begin
                for (int i = 0; i < 4; i++)
                    if (RAM_WE[i]) mem[RAM_A][8*i +: 8] <= RAM_Di[8*i +: 8];
                ram_wr_cnt <= ram_wr_cnt + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                         input logic [2:0] size, input logic wr, input logic [31:0] wdata);
        HSEL = sel; HTRANS = trans; HADDR = addr; HSIZE = size; HWRITE = wr; HWDATA = wdata;
    endtask

    task automatic idle(input logic [31:0] wdata);
        drive(1'b0, HTRANS_IDLE, 32'h0, HSIZE_BYTE, 1'b0, wdata);
    endtask

    task automatic mid();
        @(negedge HCLK);
    endtask

    task automatic next_cycle();
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        HRESETn = 1'b0;
        idle(32'h0);
        #2;
        chk("rst_hreadyout", 32'(HREADYOUT), 32'd1);
        chk("rst_hresp",     32'(HRESP),     32'd0);
        chk("rst_ram_en",    32'(RAM_EN),    32'd0);
        chk("rst_hrdata",    HRDATA,         32'h0);
        @(posedge HCLK);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;

        // 1: word write, idle commit, zero-wait read
        drive(1'b1, HTRANS_NONSEQ, 32'h10, HSIZE_WORD, 1'b1, 32'h0);
        mid(); chk("t1_waddr_ram_en", 32'(RAM_EN), 32'd0); next_cycle();
        idle(32'hDEADBEEF);
        mid(); chk("t1_wdata_hready", 32'(HREADYOUT), 32'd1); chk("t1_wdata_ram_en", 32'(RAM_EN), 32'd0); next_cycle();
        idle(32'h0);
        mid();
        chk("t1_commit_en", 32'(RAM_EN), 32'd1);
        chk("t1_commit_we", 32'(RAM_WE), 32'hF);
        chk("t1_commit_a",  32'(RAM_A),  32'd4);
        chk("t1_commit_di", RAM_Di,      32'hDEADBEEF);
        next_cycle();
        drive(1'b1, HTRANS_NONSEQ, 32'h10, HSIZE_WORD, 1'b0, 32'h0);
        mid(); chk("t1_raddr_en", 32'(RAM_EN), 32'd1); chk("t1_raddr_we", 32'(RAM_WE), 32'd0); chk("t1_raddr_a", 32'(RAM_A), 32'd4); next_cycle();
        idle(32'h0);
        mid(); chk("t1_rdata_hready", 32'(HREADYOUT), 32'd1); chk("t1_rdata", HRDATA, 32'hDEADBEEF); chk("t1_idle_en", 32'(RAM_EN), 32'd0); next_cycle();

        // 2: byte write then read of the same word, forwarded with no stall
        drive(1'b1, HTRANS_NONSEQ, 32'h21, HSIZE_BYTE, 1'b1, 32'h0);
        mid(); next_cycle();
        drive(1'b1, HTRANS_NONSEQ, 32'h20, HSIZE_WORD, 1'b0, 32'h0000AA00);
        mid(); chk("t2_no_stall", 32'(HREADYOUT), 32'd1); chk("t2_raddr_a", 32'(RAM_A), 32'd8); chk("t2_raddr_we", 32'(RAM_WE), 32'd0); next_cycle();
        idle(32'h0);
        mid(); chk("t2_fwd_rdata", HRDATA, 32'h1122AA44); chk("t2_commit_we", 32'(RAM_WE), 32'h2); next_cycle();
        idle(32'h0);
        mid(); chk("t2_idle_en", 32'(RAM_EN), 32'd0); next_cycle();

        // 3: write A, write B, read C=A -> one stall cycle committing A
        drive(1'b1, HTRANS_NONSEQ, 32'h40, HSIZE_WORD, 1'b1, 32'h0);
        mid(); next_cycle();
        drive(1'b1, HTRANS_NONSEQ, 32'h44, HSIZE_WORD, 1'b1, 32'hA0A0A0A0);
        mid(); chk("t3_wa_data_hready", 32'(HREADYOUT), 32'd1); next_cycle();
        drive(1'b1, HTRANS_NONSEQ, 32'h40, HSIZE_WORD, 1'b0, 32'hB0B0B0B0);
        mid();
        chk("t3_stall_hready", 32'(HREADYOUT), 32'd0);
        chk("t3_stall_hresp",  32'(HRESP),     32'd0);
        chk("t3_stall_we",     32'(RAM_WE),    32'hF);
        chk("t3_stall_a",      32'(RAM_A),     32'h10);
        chk("t3_stall_di",     RAM_Di,         32'hA0A0A0A0);
        next_cycle();
        mid();
        chk("t3_held_hready", 32'(HREADYOUT), 32'd1);
        chk("t3_held_en",     32'(RAM_EN),    32'd1);
        chk("t3_held_we",     32'(RAM_WE),    32'd0);
        chk("t3_held_a",      32'(RAM_A),     32'h10);
        next_cycle();
        idle(32'h0);
        mid();
        chk("t3_rdata",     HRDATA,        32'hA0A0A0A0);
        chk("t3_commit_we", 32'(RAM_WE),   32'hF);
        chk("t3_commit_a",  32'(RAM_A),    32'h11);
        chk("t3_commit_di", RAM_Di,        32'hB0B0B0B0);
        next_cycle();
        idle(32'h0);
        mid(); chk("t3_idle_en", 32'(RAM_EN), 32'd0); next_cycle();

        // 4: misaligned word -> ERR1, ERR2 (new read accepted in ERR2), RAM untouched
        wr_base = ram_wr_cnt;
        drive(1'b1, HTRANS_NONSEQ, 32'h02, HSIZE_WORD, 1'b1, 32'h0);
        mid(); chk("t4_addr_en", 32'(RAM_EN), 32'd0); chk("t4_addr_hresp", 32'(HRESP), 32'd0); next_cycle();
        idle(32'hFFFFFFFF);
        mid(); chk("t4_err1_hready", 32'(HREADYOUT), 32'd0); chk("t4_err1_hresp", 32'(HRESP), 32'd1); chk("t4_err1_en", 32'(RAM_EN), 32'd0); next_cycle();
        drive(1'b1, HTRANS_NONSEQ, 32'h00, HSIZE_WORD, 1'b0, 32'h0);
        mid();
        chk("t4_err2_hready", 32'(HREADYOUT), 32'd1);
        chk("t4_err2_hresp",  32'(HRESP),     32'd1);
        chk("t4_err2_rd_en",  32'(RAM_EN),    32'd1);
        chk("t4_err2_rd_a",   32'(RAM_A),     32'd0);
        next_cycle();
        idle(32'h0);
        mid();
        chk("t4_rdata",  HRDATA,           32'h55667788);
        chk("t4_hresp",  32'(HRESP),       32'd0);
        chk("t4_no_wr",  32'(ram_wr_cnt),  32'(wr_base));
        next_cycle();

        // 5: reset while the buffer holds a write that is committing this cycle
        drive(1'b1, HTRANS_NONSEQ, 32'h80, HSIZE_WORD, 1'b1, 32'h0);
        mid(); next_cycle();
        drive(1'b1, HTRANS_NONSEQ, 32'h84, HSIZE_WORD, 1'b1, 32'h12345678);
        mid(); next_cycle();
        idle(32'h9ABCDEF0);
        #2;
        chk("t5_pre_en", 32'(RAM_EN), 32'd1);
        chk("t5_pre_we", 32'(RAM_WE), 32'hF);
        wr_base = ram_wr_cnt;
        HRESETn = 1'b0;
        #1;
        chk("t5_rst_hready", 32'(HREADYOUT), 32'd1);
        chk("t5_rst_hresp",  32'(HRESP),     32'd0);
        chk("t5_rst_en",     32'(RAM_EN),    32'd0);
        @(posedge HCLK);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        idle(32'h0);
        mid(); chk("t5_post_en", 32'(RAM_EN), 32'd0); next_cycle();
        drive(1'b1, HTRANS_NONSEQ, 32'h80, HSIZE_WORD, 1'b0, 32'h0);
        mid(); next_cycle();
        idle(32'h0);
        mid(); chk("t5_rdata", HRDATA, 32'h0); chk("t5_no_wr", 32'(ram_wr_cnt), 32'(wr_base)); next_cycle();

        // 6: two halfword writes then a word read of the pair
        drive(1'b1, HTRANS_NONSEQ, 32'h32, HSIZE_HALF, 1'b1, 32'h0);
        mid(); next_cycle();
        drive(1'b1, HTRANS_NONSEQ, 32'h30, HSIZE_HALF, 1'b1, 32'hBEEF0000);
        mid(); next_cycle();
        drive(1'b1, HTRANS_NONSEQ, 32'h30, HSIZE_WORD, 1'b0, 32'h0000CAFE);
        mid(); chk("t6_stall_hready", 32'(HREADYOUT), 32'd0); chk("t6_stall_we", 32'(RAM_WE), 32'hC); chk("t6_stall_a", 32'(RAM_A), 32'hC); next_cycle();
        mid(); chk("t6_held_hready", 32'(HREADYOUT), 32'd1); chk("t6_held_en", 32'(RAM_EN), 32'd1); chk("t6_held_we", 32'(RAM_WE), 32'd0); next_cycle();
        idle(32'h0);
        mid(); chk("t6_rdata", HRDATA, 32'hBEEFCAFE); chk("t6_commit_we", 32'(RAM_WE), 32'h3); next_cycle();

        // 7: upper address bits alias onto word 4
        drive(1'b1, HTRANS_NONSEQ, 32'h12344010, HSIZE_WORD, 1'b0, 32'h0);
        mid(); chk("t7_alias_a", 32'(RAM_A), 32'd4); next_cycle();
        idle(32'h0);
        mid(); chk("t7_alias_rdata", HRDATA, 32'hDEADBEEF); next_cycle();

        // 8: odd halfword read and oversize write are both rejected
        drive(1'b1, HTRANS_NONSEQ, 32'h01, HSIZE_HALF, 1'b0, 32'h0);
        mid(); chk("t8_half_en", 32'(RAM_EN), 32'd0); next_cycle();
        idle(32'h0);
        mid(); chk("t8_half_err1_hready", 32'(HREADYOUT), 32'd0); chk("t8_half_err1_hresp", 32'(HRESP), 32'd1); next_cycle();
        mid(); chk("t8_half_err2_hready", 32'(HREADYOUT), 32'd1); chk("t8_half_err2_hresp", 32'(HRESP), 32'd1); next_cycle();
        mid(); chk("t8_half_ok_hresp", 32'(HRESP), 32'd0); next_cycle();
        drive(1'b1, HTRANS_NONSEQ, 32'h00, 3'd3, 1'b1, 32'h0);
        mid(); chk("t8_size3_en", 32'(RAM_EN), 32'd0); next_cycle();
        idle(32'h0);
        mid(); chk("t8_size3_hresp", 32'(HRESP), 32'd1); chk("t8_size3_en_err", 32'(RAM_EN), 32'd0); next_cycle();
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_ram_ctrl.md
Name: ahb_ram_ctrl

Overview:
- AHB-Lite slave that fronts the 4Kx32 single-port synchronous SRAM macro. It drives the macro's CLK/EN/WE/Di/A pins and consumes its Do.
- Zero-wait-state reads and writes through a one-entry posted write buffer with read-forwarding.
- Sits between the AHB bus matrix and the RAM macro. Misaligned or oversize transfers get an ERROR response.

Parameters:
- AW, 12, word-address width driven to the RAM; byte address bits used are HADDR[AW+1:0].

Ports:
- HCLK  in  1  bus clock; also drives RAM clock
- HRESETn  in  1  asynchronous active-low reset
- HSEL  in  1  slave select
- HADDR  in  32  byte address
- HTRANS  in  2  transfer type
- HSIZE  in  3  transfer size
- HWRITE  in  1  write=1
- HREADY  in  1  bus-level ready
- HWDATA  in  32  write data (data phase)
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0=OKAY, 1=ERROR
- HRDATA  out  32  read data
- RAM_EN  out  1  RAM enable
- RAM_WE  out  4  RAM byte write enables
- RAM_A  out  AW  RAM word address
- RAM_Di  out  32  RAM write data
- RAM_Do  in  32  RAM read data, valid the cycle after EN

Behaviour:
- Interface timing:
  - One clock, HCLK. Reset HRESETn is asynchronous and active-low.
  - All state is cleared on reset.
- Reset values:
  - HREADYOUT=1, HRESP=0.
  - buf_valid=0; the FSM is in OK.
- Accept and lanes:
  - An address phase is accepted when HSEL & HTRANS[1] & HREADY.
  - Byte lanes are derived from HSIZE/HADDR[1:0] (byte, halfword, word).
- Illegal transfers:
  - A transfer is illegal if HSIZE>2, or HSIZE=1 with HADDR[0]=1, or HSIZE=2 with HADDR[1:0]!=0.
  - Illegal transfers cause no RAM access and no buffer change.
- FSM states: OK, STALL, ERR1, ERR2.
  - OK: HREADYOUT=1, HRESP=0.
  - Illegal accepted address -> ERR1 (HREADYOUT=0, HRESP=1) -> ERR2 (HREADYOUT=1, HRESP=1) -> OK.
  - A new address presented during ERR2 is treated normally.
- Reads:
  - In the accepted address-phase cycle: RAM_EN=1, RAM_WE=0, RAM_A=HADDR[AW+1:2].
  - Next cycle (data phase): HRDATA=RAM_Do with per-byte replacement by buf_data where buf_valid & buf_addr==latched read address & buf_mask[lane].
  - Latency is 0 wait states.
- Writes:
  - Address phase latches the word address and byte mask; no RAM access.
  - On the data-phase cycle with HREADYOUT=1, HWDATA is captured into the buffer at the clock edge. buf_valid, buf_addr, buf_mask and buf_data are updated.
- Commit:
  - In any cycle with buf_valid=1 and no read being issued to the RAM: RAM_EN=1, RAM_WE=buf_mask, RAM_A=buf_addr, RAM_Di=buf_data.
  - buf_valid clears at the edge unless refilled the same edge.
- Read has priority over commit for the RAM port.
- Conflict (write data phase, buf_valid=1, read address phase presented in the same cycle):
  - Enter STALL: HREADYOUT=0 for one cycle.
  - During the stall: commit the old buffer, issue no read, capture no HWDATA.
  - Next cycle (OK): HWDATA is captured and the held read is issued.
- Idle cycles: RAM_EN=0 unless a commit is pending.
- Forwarding covers the write whose data phase coincides with the read address phase (it is in the buffer during the read data phase).
- Reset mid-operation: any buffered write is discarded; RAM_EN drops immediately.
- Address bits above HADDR[AW+1] are ignored (aliasing).

Decomposition:
- Shared AHB package: HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ), HSIZE encodings, HRESP_OKAY/ERROR, and the FSM state typedef.
- Sub-module ram_write_buffer holds the buffer registers, address compare and byte-merge mux.
- The AHB FSM, lane decode and RAM port arbitration stay in ahb_ram_ctrl.

Test Plan:
1. Word write 0xDEADBEEF to 0x10, then an idle cycle, then a read of 0x10.
   - Commit in the idle cycle: RAM_WE=4'hF, RAM_A=4.
   - The read returns 0xDEADBEEF with 0 wait states.
2. Write byte 0xAA to 0x21 immediately followed by a read of word 0x20, with RAM pre-holding 0x11223344.
   - HRDATA=0x1122AA44, forwarded; no stall.
3. Write A, write B, read C back-to-back.
   - One STALL cycle (HREADYOUT=0) in which write A commits.
   - B is buffered, C reads correctly.
   - Afterwards B commits on the first free cycle.
4. HSIZE=2 at 0x02.
   - ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1).
   - RAM_EN stays 0; a subsequent read shows the RAM unchanged.
5. Assert HRESETn=0 while buf_valid=1.
   - HREADYOUT=1, HRESP=0, RAM_EN=0 immediately.
   - The buffered write is never committed.
6. Halfword writes 0xBEEF to 0x32, then 0xCAFE to 0x30, then a word read of 0x30.
   - Expected HRDATA=0xBEEFCAFE.
   - RAM_WE pulses 4'b1100 then 4'b0011.
